// File: rtl/dds_cmd_pkg.sv
// Shared definitions for the DDS command decoder.
// Holds the opcode values, the FSM state encoding, the readback selector codes and
// the saturating-increment helper used by the error counter. The spi_slave bench
// reuses the opcodes from here.
package dds_cmd_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_FTW_LO = 8'h10;
    localparam logic [7:0] OP_FTW_HI = 8'h11;
    localparam logic [7:0] OP_PHASE  = 8'h20;
    localparam logic [7:0] OP_AMP    = 8'h30;
    localparam logic [7:0] OP_WAVE   = 8'h40;
    localparam logic [7:0] OP_COMMIT = 8'h50;
    localparam logic [7:0] OP_RDBK   = 8'h60;

    localparam logic [7:0] SEL_FTW_LO = 8'd0;
    localparam logic [7:0] SEL_FTW_HI = 8'd1;
    localparam logic [7:0] SEL_PHASE  = 8'd2;
    localparam logic [7:0] SEL_AMP    = 8'd3;
    localparam logic [7:0] SEL_WAVE   = 8'd4;
    localparam logic [7:0] SEL_ERR    = 8'd5;

    localparam logic [23:0] RDBK_BAD = 24'hEEEEEE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_REPLY   = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/dds_cmd_decoder_if.sv
// SPI slave <-> command decoder handshake bundle.
//   rd_data_available / rd_data / rd_ack : incoming 32-bit command frames
//   wr_buffer_free / wr_en / wr_data     : outgoing 24-bit readback replies
// master = spi_slave side, slave = decoder side.
interface dds_cmd_decoder_if;
    logic        rd_data_available;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic        wr_buffer_free;
    logic        wr_en;
    logic [23:0] wr_data;

    modport master (
        output rd_data_available, rd_data, wr_buffer_free,
        input  rd_ack, wr_en, wr_data
    );

    modport slave (
        input  rd_data_available, rd_data, wr_buffer_free,
        output rd_ack, wr_en, wr_data
    );
endinterface

// File: rtl/dds_readback_mux.sv
// Registered readback multiplexer.
// Ports: clk, reset (sync, active-high), load_i captures a new reply, sel_i picks
// the live register, ftw_i/phase_i/amp_i/wave_i/err_i are the live values,
// reply_o is the captured 24-bit reply (zero after reset).
module dds_readback_mux
    import dds_cmd_pkg::*;
#(
    parameter int PHASE_W = 12,
    parameter int AMP_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [7:0]         sel_i,
    input  logic [31:0]        ftw_i,
    input  logic [PHASE_W-1:0] phase_i,
    input  logic [AMP_W-1:0]   amp_i,
    input  logic [1:0]         wave_i,
    input  logic [7:0]         err_i,
    output logic [23:0]        reply_o
);

    logic [23:0] reply_d;
    logic [23:0] reply_q;

    // Select the reply word for the requested live register.
    always_comb begin
        reply_d = RDBK_BAD;
        case (sel_i)
            SEL_FTW_LO: reply_d = ftw_i[23:0];
            SEL_FTW_HI: reply_d = {16'h0000, ftw_i[31:24]};
            SEL_PHASE:  reply_d = 24'(phase_i);
            SEL_AMP:    reply_d = 24'(amp_i);
            SEL_WAVE:   reply_d = {22'h000000, wave_i};
            SEL_ERR:    reply_d = {16'h0000, err_i};
            default:    reply_d = RDBK_BAD;
        endcase
    end

    // Capture the reply when a readback executes; hold it otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            reply_q <= 24'h000000;
        end else if (load_i) begin
            reply_q <= reply_d;
        end else begin
            reply_q <= reply_q;
        end
    end

    assign reply_o = reply_q;

endmodule

// File: rtl/dds_cmd_decoder.sv
// DDS command decoder.
// Takes {payload[23:0], opcode[7:0]} frames from the SPI slave, loads shadow
// registers, commits them to the live DDS controls, and answers readbacks.
// Ports: clk, reset (sync, active-high), bus (slave modport: frame in, reply out),
// ftw/phase/amplitude/wave_sel live DDS controls, dds_update commit pulse,
// err_count saturating unknown-opcode counter.
module dds_cmd_decoder
    import dds_cmd_pkg::*;
#(
    parameter int              PHASE_W   = 12,
    parameter int              AMP_W     = 10,
    parameter logic [AMP_W-1:0] AMP_RESET = 10'h3FF
) (
    input  logic               clk,
    input  logic               reset,
    dds_cmd_decoder_if.slave   bus,
    output logic [31:0]        ftw,
    output logic [PHASE_W-1:0] phase,
    output logic [AMP_W-1:0]   amplitude,
    output logic [1:0]         wave_sel,
    output logic               dds_update,
    output logic [7:0]         err_count
);

    state_e             state_q;
    logic [31:0]        cmd_q;
    logic [31:0]        sh_ftw_q;
    logic [PHASE_W-1:0] sh_phase_q;
    logic [AMP_W-1:0]   sh_amp_q;
    logic [1:0]         sh_wave_q;
    logic [31:0]        ftw_q;
    logic [PHASE_W-1:0] phase_q;
    logic [AMP_W-1:0]   amp_q;
    logic [1:0]         wave_q;
    logic [7:0]         err_q;
    logic               rd_ack_q;
    logic               wr_en_q;
    logic               commit_q;
    logic               dds_update_q;
    logic [7:0]         op_s;
    logic [23:0]        pl_s;
    logic               rdbk_load_s;
    logic [23:0]        reply_s;

    assign op_s        = cmd_q[7:0];
    assign pl_s        = cmd_q[31:8];
    assign rdbk_load_s = (state_q == ST_EXEC) && (op_s == OP_RDBK);

    // Command FSM plus shadow/live register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= 32'h0000_0000;
            sh_ftw_q     <= 32'h0000_0000;
            sh_phase_q   <= '0;
            sh_amp_q     <= AMP_RESET;
            sh_wave_q    <= 2'd0;
            ftw_q        <= 32'h0000_0000;
            phase_q      <= '0;
            amp_q        <= AMP_RESET;
            wave_q       <= 2'd0;
            err_q        <= 8'h00;
            rd_ack_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            commit_q     <= 1'b0;
            dds_update_q <= 1'b0;
        end else begin
            rd_ack_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            commit_q     <= 1'b0;
            // Delay the update pulse one cycle so it trails the live values.
            dds_update_q <= commit_q;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rd_data_available) begin
                        cmd_q   <= bus.rd_data;
                        state_q <= ST_EXEC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rd_ack_q <= 1'b1;
                    state_q  <= (op_s == OP_RDBK) ? ST_REPLY : ST_RELEASE;
                    case (op_s)
                        OP_NOP:    begin end
                        OP_FTW_LO: sh_ftw_q[23:0]  <= pl_s;
                        OP_FTW_HI: sh_ftw_q[31:24] <= pl_s[7:0];
                        OP_PHASE:  sh_phase_q      <= pl_s[PHASE_W-1:0];
                        OP_AMP:    sh_amp_q        <= pl_s[AMP_W-1:0];
                        OP_WAVE:   sh_wave_q       <= pl_s[1:0];
                        OP_COMMIT: begin
                            ftw_q    <= sh_ftw_q;
                            phase_q  <= sh_phase_q;
                            amp_q    <= sh_amp_q;
                            wave_q   <= sh_wave_q;
                            commit_q <= 1'b1;
                        end
                        OP_RDBK:   begin end
                        default:   err_q <= sat_inc8(err_q);
                    endcase
                end
                ST_REPLY: begin
                    if (bus.wr_buffer_free) begin
                        wr_en_q <= 1'b1;
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_REPLY;
                    end
                end
                ST_RELEASE: begin
                    // The slave keeps the frame up until its SPI transfer ends.
                    if (!bus.rd_data_available) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RELEASE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dds_readback_mux #(
        .PHASE_W (PHASE_W),
        .AMP_W   (AMP_W)
    ) u_rdbk (
        .clk     (clk),
        .reset   (reset),
        .load_i  (rdbk_load_s),
        .sel_i   (pl_s[7:0]),
        .ftw_i   (ftw_q),
        .phase_i (phase_q),
        .amp_i   (amp_q),
        .wave_i  (wave_q),
        .err_i   (err_q),
        .reply_o (reply_s)
    );

    assign bus.rd_ack  = rd_ack_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = reply_s;
    assign ftw         = ftw_q;
    assign phase       = phase_q;
    assign amplitude   = amp_q;
    assign wave_sel    = wave_q;
    assign dds_update  = dds_update_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_dds_cmd_decoder.sv
module tb_dds_cmd_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] ftw;
    logic [11:0] phase;
    logic [9:0]  amplitude;
    logic [1:0]  wave_sel;
    logic        dds_update;
    logic [7:0]  err_count;

    dds_cmd_decoder_if bus();

    dds_cmd_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ftw        (ftw),
        .phase      (phase),
        .amplitude  (amplitude),
        .wave_sel   (wave_sel),
        .dds_update (dds_update),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int wr_cnt = 0;
    int upd_cnt = 0;

    // Expected replies, pushed when a readback frame is issued.
    logic [23:0] exp_q[$];

    // Reference model state.
    logic [31:0] m_sh_ftw, m_ftw;
    logic [11:0] m_sh_ph, m_ph;
    logic [9:0]  m_sh_amp, m_amp;
    logic [1:0]  m_sh_wave, m_wave;
    logic [7:0]  m_err;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.rd_ack) ack_cnt <= ack_cnt + 1;
        if (bus.wr_en)  wr_cnt  <= wr_cnt + 1;
        if (dds_update) upd_cnt <= upd_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_sh_ftw = 32'h0; m_ftw = 32'h0;
        m_sh_ph = 12'h0;  m_ph = 12'h0;
        m_sh_amp = 10'h3FF; m_amp = 10'h3FF;
        m_sh_wave = 2'd0; m_wave = 2'd0;
        m_err = 8'h00;
    endtask

    function automatic logic [23:0] model_reply(input logic [7:0] sel);
        case (sel)
            8'd0:    return m_ftw[23:0];
            8'd1:    return {16'h0, m_ftw[31:24]};
            8'd2:    return {12'h0, m_ph};
            8'd3:    return {14'h0, m_amp};
            8'd4:    return {22'h0, m_wave};
            8'd5:    return {16'h0, m_err};
            default: return 24'hEEEEEE;
        endcase
    endfunction

    task automatic model_apply(input logic [7:0] op, input logic [23:0] pl);
        case (op)
            8'h00: ;
            8'h10: m_sh_ftw[23:0] = pl;
            8'h11: m_sh_ftw[31:24] = pl[7:0];
            8'h20: m_sh_ph = pl[11:0];
            8'h30: m_sh_amp = pl[9:0];
            8'h40: m_sh_wave = pl[1:0];
            8'h50: begin
                m_ftw = m_sh_ftw; m_ph = m_sh_ph; m_amp = m_sh_amp; m_wave = m_sh_wave;
            end
            8'h60: exp_q.push_back(model_reply(pl[7:0]));
            default: m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
        endcase
    endtask

    task automatic wait_ack(output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.rd_ack) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_reply();
        bit seen;
        logic [23:0] exp;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wr_en) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reply_timeout wr_en never asserted");
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL reply_unexpected got %h with nothing expected", bus.wr_data);
        end else begin
            exp = exp_q.pop_front();
            if (bus.wr_data !== exp) begin
                errors++;
                $display("FAIL reply_data got %h expected %h", bus.wr_data, exp);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [23:0] pl);
        bit got;
        int lat;
        model_apply(op, pl);
        bus.rd_data = {pl, op};
        bus.rd_data_available = 1'b1;
        wait_ack(got, lat);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout op %h", op);
        end
        if (op == 8'h60) wait_reply();
        bus.rd_data_available = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
        checks++; if (ftw !== 32'h0) begin errors++; $display("FAIL reset_ftw got %h expected 0", ftw); end
        checks++; if (phase !== 12'h0) begin errors++; $display("FAIL reset_phase got %h expected 0", phase); end
        checks++; if (amplitude !== 10'h3FF) begin errors++; $display("FAIL reset_amp got %h expected 3ff", amplitude); end
        checks++; if (wave_sel !== 2'd0) begin errors++; $display("FAIL reset_wave got %h expected 0", wave_sel); end
        checks++; if (err_count !== 8'h0) begin errors++; $display("FAIL reset_err got %h expected 0", err_count); end
        checks++; if (dds_update !== 1'b0) begin errors++; $display("FAIL reset_update got %b expected 0", dds_update); end
        checks++; if (bus.wr_en !== 1'b0 || bus.wr_data !== 24'h0) begin errors++; $display("FAIL reset_wr got %b/%h expected 0/0", bus.wr_en, bus.wr_data); end
        checks++; if (ack_cnt != 0) begin errors++; $display("FAIL reset_ack got %0d pulses expected 0", ack_cnt); end
    endtask

    task automatic test_ftw_commit();
        int a0, u0, lat;
        bit got;
        a0 = ack_cnt; u0 = upd_cnt;
        send_frame(8'h10, 24'h123456);
        send_frame(8'h11, 24'h0000AB);
        checks++; if (ftw !== 32'h0) begin errors++; $display("FAIL ftw_before_commit got %h expected 0", ftw); end
        model_apply(8'h50, 24'h0);
        bus.rd_data = 32'h0000_0050;
        bus.rd_data_available = 1'b1;
        wait_ack(got, lat);
        checks++; if (!got || lat != 2) begin errors++; $display("FAIL ack_latency got %0d expected 2", lat); end
        checks++; if (ftw !== 32'hAB123456) begin errors++; $display("FAIL ftw_commit got %h expected ab123456", ftw); end
        checks++; if (dds_update !== 1'b0) begin errors++; $display("FAIL update_early got %b expected 0", dds_update); end
        bus.rd_data_available = 1'b0;
        @(negedge clk);
        checks++; if (dds_update !== 1'b1) begin errors++; $display("FAIL update_pulse got %b expected 1", dds_update); end
        @(negedge clk);
        checks++; if (dds_update !== 1'b0) begin errors++; $display("FAIL update_width got %b expected 0", dds_update); end
        repeat (2) @(negedge clk);
        checks++; if (upd_cnt - u0 != 1) begin errors++; $display("FAIL update_count got %0d expected 1", upd_cnt - u0); end
        checks++; if (ack_cnt - a0 != 3) begin errors++; $display("FAIL ack_count got %0d expected 3", ack_cnt - a0); end
    endtask

    task automatic test_shadow_isolation();
        send_frame(8'h20, 24'h000ABC);
        send_frame(8'h30, 24'h000155);
        send_frame(8'h40, 24'h000002);
        send_frame(8'h60, 24'h000002);
        checks++; if (phase !== 12'h0 || amplitude !== 10'h3FF) begin errors++; $display("FAIL shadow_leak phase %h amp %h expected 0/3ff", phase, amplitude); end
        send_frame(8'h50, 24'h0);
        send_frame(8'h60, 24'h000002);
        send_frame(8'h60, 24'h000003);
        send_frame(8'h60, 24'h000004);
        send_frame(8'h60, 24'h000001);
        send_frame(8'h00, 24'hFFFFFF);
        checks++; if (wave_sel !== 2'd2 || err_count !== 8'h0) begin errors++; $display("FAIL live_after_commit wave %h err %h expected 2/0", wave_sel, err_count); end
    endtask

    task automatic test_backpressure();
        int a0, w0, lat;
        bit got;
        a0 = ack_cnt; w0 = wr_cnt;
        bus.wr_buffer_free = 1'b0;
        model_apply(8'h60, 24'h000000);
        bus.rd_data = 32'h0000_0060;
        bus.rd_data_available = 1'b1;
        wait_ack(got, lat);
        checks++; if (!got) begin errors++; $display("FAIL bp_ack_timeout no ack"); end
        repeat (20) @(negedge clk);
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL bp_hold got %0d strobes expected 0", wr_cnt - w0); end
        bus.wr_buffer_free = 1'b1;
        wait_reply();
        repeat (6) @(negedge clk);
        checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL bp_wr_count got %0d expected 1", wr_cnt - w0); end
        checks++; if (ack_cnt - a0 != 1) begin errors++; $display("FAIL bp_reexec got %0d acks expected 1", ack_cnt - a0); end
        bus.rd_data_available = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 300; i++) send_frame(8'h7F, 24'(i));
        checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_saturate got %h expected ff", err_count); end
        send_frame(8'h60, 24'h000005);
        send_frame(8'h60, 24'h000009);
    endtask

    task automatic test_reset_in_reply();
        int w0, lat;
        bit got;
        w0 = wr_cnt;
        bus.wr_buffer_free = 1'b0;
        bus.rd_data = 32'h0000_0360;
        bus.rd_data_available = 1'b1;
        wait_ack(got, lat);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        checks++; if (ftw !== 32'h0 || phase !== 12'h0 || amplitude !== 10'h3FF || wave_sel !== 2'd0) begin
            errors++; $display("FAIL rst_live ftw %h ph %h amp %h wave %h expected 0/0/3ff/0", ftw, phase, amplitude, wave_sel); end
        checks++; if (err_count !== 8'h0 || bus.wr_data !== 24'h0 || bus.rd_ack !== 1'b0) begin
            errors++; $display("FAIL rst_misc err %h wr_data %h ack %b expected 0/0/0", err_count, bus.wr_data, bus.rd_ack); end
        bus.rd_data_available = 1'b0;
        reset = 1'b0;
        bus.wr_buffer_free = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL rst_abandon got %0d strobes expected 0", wr_cnt - w0); end
        send_frame(8'h60, 24'h000003);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        reset = 1'b1;
        bus.rd_data_available = 1'b0;
        bus.rd_data = 32'h0;
        bus.wr_buffer_free = 1'b1;
        model_reset();
        test_reset();
        test_ftw_commit();
        test_shadow_isolation();
        test_backpressure();
        test_err_saturation();
        test_reset_in_reply();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
